// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I fetch stage.
// Opcode values are also consumed by the control unit.
package fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    S_REQ  = 1'b0,
    S_WAIT = 1'b1
  } fetch_state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  function automatic logic [XLEN-1:0] word_align(
    input logic [XLEN-1:0] a
  );
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_out_reg.sv
// One-entry output register between fetch and decode.
// Flush beats load beats consume.
module if_out_reg
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            consume,
  input  logic            flush,
  input  logic [XLEN-1:0] load_pc,
  input  logic [31:0]     load_instr,
  output logic            valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc
);

  logic            valid_q, valid_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = load_instr;
      pc_d    = load_pc;
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid = valid_q;
  assign instr = instr_q;
  assign pc    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction fetch: PC, single-outstanding imem request FSM,
// redirect handling and the output register feeding decode.
module fetch_unit #(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic            if_valid,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4,
  input  logic            id_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target
);

  import fetch_pkg::*;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            drop_q, drop_d;

  logic req_fire;
  logic resp_fire;
  logic out_load;
  logic out_consume;

  assign imem_req_valid = !reset && (state_q == S_REQ)
                        && (!if_valid || id_ready);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign resp_fire      = !reset && (state_q == S_WAIT)
                        && imem_resp_valid;
  assign out_load       = resp_fire && !drop_q && !redirect_valid;
  assign out_consume    = if_valid && id_ready;
  assign if_pc_plus4    = if_pc + XLEN'(4);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    unique case (state_q)
      S_REQ: begin
        if (req_fire) begin
          state_d    = S_WAIT;
          fetch_pc_d = pc_q;
          pc_d       = pc_q + XLEN'(4);
          // a redirect in the issue cycle makes this request stale
          drop_d     = redirect_valid;
        end
      end
      S_WAIT: begin
        if (resp_fire) begin
          state_d = S_REQ;
          drop_d  = 1'b0;
        end else if (redirect_valid) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = S_REQ;
    endcase
    if (redirect_valid) begin
      pc_d = word_align(redirect_target);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      fetch_pc_q <= '0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
    end
  end

  if_out_reg u_out (
    .clk        (clk),
    .reset      (reset),
    .load       (out_load),
    .consume    (out_consume),
    .flush      (redirect_valid),
    .load_pc    (fetch_pc_q),
    .load_instr (imem_resp_data),
    .valid      (if_valid),
    .instr      (if_instr),
    .pc         (if_pc)
  );

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage for the RV32I core. It holds the PC and issues one instruction-memory request at a time over a valid/ready handshake. Each returned word goes into a one-entry output register that drives the decode/control stage (opcode = instr[6:0], funct3 = instr[14:12]). Redirects come from branch/jump resolution (Branch/Jump outcome plus computed target) and flush any in-flight or buffered instruction.

Parameters:
XLEN, 32, data/address width (only 32 is supported)
RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  word-aligned fetch address
imem_resp_valid  in  1  instruction word returned (≥1 cycle after acceptance)
imem_resp_data  in  32  instruction word
if_valid  out  1  output register holds a valid instruction
if_instr  out  32  fetched instruction
if_pc  out  XLEN  address of if_instr
if_pc_plus4  out  XLEN  if_pc + 4, for the JAL/JALR link value
id_ready  in  1  downstream consumes the output this cycle when if_valid=1
redirect_valid  in  1  taken branch or jump
redirect_target  in  XLEN  new PC; bits [1:0] forced to 0 internally

Behaviour:
- Clocking and reset: single clock domain, synchronous active-high reset; all state updates on the rising clk edge.
- Reset values: pc=RESET_PC, state=S_REQ, if_valid=0, if_instr=0x0000_0013 (NOP), if_pc=0, drop=0. imem_req_valid is forced to 0 while reset=1.
- Reset is honoured mid-transaction. The memory shares reset and cancels any outstanding transaction, and imem_resp_valid is ignored while reset=1.
- FSM states:
  - S_REQ: imem_req_valid = (!if_valid || id_ready); imem_req_addr = pc.
  - S_WAIT: exactly one request is outstanding.
- S_REQ transitions:
  - On handshake (req_valid && req_ready): fetch_pc <= pc, pc <= pc+4, go to S_WAIT.
  - Otherwise stay in S_REQ.
- S_WAIT transitions:
  - On imem_resp_valid with drop=0: if_valid<=1, if_instr<=resp_data, if_pc<=fetch_pc, then go to S_REQ.
  - On imem_resp_valid with drop=1: discard the word, clear drop, go to S_REQ.
- Issue rule guarantees no overflow: a request issues only when the output register is empty or is being consumed that cycle. The output register is therefore always empty when a response returns.
- Consumption: if_valid && id_ready with no capture in the same cycle clears if_valid.
- Stall: if_valid && !id_ready holds if_instr/if_pc stable and blocks new requests. An outstanding response still lands normally, because the request was only issued with space available.
- if_pc_plus4 = if_pc + 4, combinational, modulo 2^32.
- Redirect has highest priority over all pc/output updates:
  - pc <= {target[31:2],2'b00} and if_valid <= 0 in the same cycle.
  - In S_WAIT: drop <= 1, so the pending response is discarded.
  - In S_REQ with a handshake in the same cycle: the accepted request is stale. Go to S_WAIT with drop=1, and pc takes the target, not pc+4.
  - In S_WAIT with resp_valid in the same cycle: the response is discarded, state goes to S_REQ, drop stays 0.
- PC arithmetic wraps: 0xFFFF_FFFC + 4 = 0x0000_0000.
- Latency: request-to-if_valid = memory latency + 1 register stage. At most one request is outstanding.

Decomposition:
- Package fetch_pkg:
  - XLEN
  - NOP_INSTR = 32'h0000_0013
  - fetch state enum {S_REQ, S_WAIT}
  - opcode constants shared with the control unit (OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM)
- One sub-module, if_out_reg: the one-entry valid/instr/pc holding register with load, consume and flush inputs. The FSM and pc live in fetch_unit.

Test Plan:
- Reset release with RESET_PC=0x1000, req_ready=1 -> first cycle after reset: req_valid=1, req_addr=0x1000; if_valid=0 throughout reset.
- Streaming, ready=1, 1-cycle response, words 0x00500093 and 0x00A00113 -> if_instr=0x00500093 with if_pc=0x1000 and if_pc_plus4=0x1004; next if_instr=0x00A00113 with if_pc=0x1004; next request addr 0x1008.
- id_ready=0 for 3 cycles while if_valid=1 -> if_instr/if_pc constant, req_valid=0; on id_ready=1, one request issues the same cycle.
- redirect_target=0x2002 asserted while in S_WAIT for 0x1008 -> old response discarded (if_valid stays 0); next req_addr=0x2000; first output has if_pc=0x2000.
- redirect in the same cycle as the handshake for 0x100C -> the 0x100C word never appears on if_instr; next request is 0x2000.
- reset asserted in S_WAIT with resp_valid high during reset -> if_valid=0 after reset; first request addr = RESET_PC.
